// File: rtl/pulse_meter_pkg.sv
// rtl/pulse_meter_pkg.sv - shared constants for the pulse rate meter and trigger-path helpers

package pulse_meter_pkg;

   // Default widths for the edge counter and the gate length
   localparam int P_CNT_WIDTH_DEF  = 32;
   localparam int P_GATE_WIDTH_DEF = 32;

   // Meter FSM encodings; the two spare codes are treated as illegal
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_GATE = 2'b01;

endpackage : pulse_meter_pkg

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector for clk-synchronous pulse streams

module rise_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_in,
   output logic o_rise
);

   logic r_in_d;

   // Previous-cycle copy of the input, tracked continuously so gate boundaries never see a stale value
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_in_d <= 1'b0;
      end else begin
         r_in_d <= i_in;
      end
   end

   // A rise is high now and low last cycle; a level already high yields nothing
   assign o_rise = i_in & ~r_in_d;

endmodule : rise_detect

// File: rtl/pulse_rate_meter.sv
// rtl/pulse_rate_meter.sv - gated edge counter with valid/ack publish; PULSE_RATE_METER_SATURATE_EN selects saturate vs wrap

module pulse_rate_meter
   import pulse_meter_pkg::*;
#(
   parameter int P_CNT_WIDTH  = P_CNT_WIDTH_DEF,
   parameter int P_GATE_WIDTH = P_GATE_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in,
   input  logic                    enable,
   input  logic [P_GATE_WIDTH-1:0] gate_len,
   output logic [P_CNT_WIDTH-1:0]  count_out,
   output logic                    count_valid,
   input  logic                    count_ack,
   output logic                    overflow,
   output logic                    missed
);

   localparam logic [P_GATE_WIDTH-1:0] C_GATE_ONE = {{(P_GATE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [P_CNT_WIDTH-1:0]  C_CNT_ONE  = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]              r_state;
   logic [P_GATE_WIDTH-1:0] r_gate_ctr;
   logic [P_GATE_WIDTH-1:0] r_gate_len_q;
   logic [P_CNT_WIDTH-1:0]  r_edge_cnt;
   logic                    r_sat;

   logic [P_CNT_WIDTH-1:0]  r_count_out;
   logic                    r_count_valid;
   logic                    r_overflow;
   logic                    r_missed;

   logic                    w_rise;
   logic                    w_start;
   logic                    w_gate_end;
   logic                    w_accept;
   logic                    w_cnt_max;
   logic [P_CNT_WIDTH-1:0]  w_next_cnt;
   logic                    w_next_sat;

   rise_detect u_rise_detect (
      .i_clk   (clk),
      .i_reset (reset),
      .i_in    (in),
      .o_rise  (w_rise)
   );

   // A gate may open (or reopen) whenever running and the programmed length is nonzero
   assign w_start    = enable && (gate_len != '0);
   // Last counting cycle of a gate that is still enabled; an enable drop here is an abort
   assign w_gate_end = (r_state == S_GATE) && enable && (r_gate_ctr == (r_gate_len_q - C_GATE_ONE));
   // A result may load when the slot is free or is being freed this very cycle
   assign w_accept   = !r_count_valid || count_ack;
   assign w_cnt_max  = (r_edge_cnt == '1);

   // Count including this cycle's rise, so the gate-end cycle contributes to the published value
   always_comb begin
      w_next_cnt = r_edge_cnt;
      w_next_sat = r_sat;
      if (w_rise) begin
`ifdef PULSE_RATE_METER_SATURATE_EN
         if (w_cnt_max) begin
            w_next_sat = 1'b1;
         end else begin
            w_next_cnt = r_edge_cnt + C_CNT_ONE;
         end
`else
         w_next_cnt = r_edge_cnt + C_CNT_ONE;
         if (w_cnt_max) begin
            w_next_sat = 1'b1;
         end
`endif
      end
   end

   // Gate sequencing: idle, counting, and seamless restart at gate end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_gate_ctr   <= '0;
         r_gate_len_q <= '0;
         r_edge_cnt   <= '0;
         r_sat        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_gate_ctr <= '0;
               r_edge_cnt <= '0;
               r_sat      <= 1'b0;
               if (w_start) begin
                  r_gate_len_q <= gate_len;
                  r_state      <= S_GATE;
               end
            end
            S_GATE: begin
               if (!enable) begin
                  r_state    <= S_IDLE;
                  r_gate_ctr <= '0;
                  r_edge_cnt <= '0;
                  r_sat      <= 1'b0;
               end else if (w_gate_end) begin
                  r_gate_ctr <= '0;
                  r_edge_cnt <= '0;
                  r_sat      <= 1'b0;
                  if (w_start) begin
                     r_gate_len_q <= gate_len;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_gate_ctr <= r_gate_ctr + C_GATE_ONE;
                  r_edge_cnt <= w_next_cnt;
                  r_sat      <= w_next_sat;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_gate_ctr <= '0;
               r_edge_cnt <= '0;
               r_sat      <= 1'b0;
            end
         endcase
      end
   end

   // Result register and handshake: publish, drop-and-flag, or clear on acknowledge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count_out   <= '0;
         r_count_valid <= 1'b0;
         r_overflow    <= 1'b0;
         r_missed      <= 1'b0;
      end else if (w_gate_end) begin
         if (w_accept) begin
            r_count_out   <= w_next_cnt;
            r_overflow    <= w_next_sat;
            r_count_valid <= 1'b1;
            r_missed      <= 1'b0;
         end else begin
            r_missed <= 1'b1;
         end
      end else if (count_ack && r_count_valid) begin
         r_count_valid <= 1'b0;
         r_missed      <= 1'b0;
      end
   end

   assign count_out   = r_count_out;
   assign count_valid = r_count_valid;
   assign overflow    = r_overflow;
   assign missed      = r_missed;

endmodule : pulse_rate_meter

// File: tb/tb_pulse_rate_meter.sv
// tb/tb_pulse_rate_meter.sv - self-checking scoreboard bench for pulse_rate_meter

module tb_pulse_rate_meter;

   typedef struct {
      logic [31:0] c32;
      logic        s32;
      logic [3:0]  c4;
      logic        s4;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        pin;
   logic        enable;
   logic [31:0] gate_len;
   logic        count_ack;

   logic [31:0] count_out;
   logic        count_valid;
   logic        overflow;
   logic        missed;

   logic [3:0]  count_out4;
   logic        count_valid4;
   logic        overflow4;
   logic        missed4;

   int          n_checks;
   int          n_errors;
   exp_t        sb_q[$];
   logic [31:0] last_cnt;

   logic        m_prev;
   logic [31:0] m_c32;
   logic        m_s32;
   logic [3:0]  m_c4;
   logic        m_s4;
   int          m_cyc;

   pulse_rate_meter #(.P_CNT_WIDTH(32), .P_GATE_WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in          (pin),
      .enable      (enable),
      .gate_len    (gate_len),
      .count_out   (count_out),
      .count_valid (count_valid),
      .count_ack   (count_ack),
      .overflow    (overflow),
      .missed      (missed)
   );

   pulse_rate_meter #(.P_CNT_WIDTH(4), .P_GATE_WIDTH(32)) dut_w4 (
      .clk         (clk),
      .reset       (reset),
      .in          (pin),
      .enable      (enable),
      .gate_len    (gate_len),
      .count_out   (count_out4),
      .count_valid (count_valid4),
      .count_ack   (count_ack),
      .overflow    (overflow4),
      .missed      (missed4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_gate();
      m_c32 = '0;
      m_s32 = 1'b0;
      m_c4  = '0;
      m_s4  = 1'b0;
      m_cyc = 0;
   endtask

   task automatic start_gate(input int len, input logic init_in);
      pin      = init_in;
      m_prev   = init_in;
      enable   = 1'b1;
      gate_len = len;
      tick();
      begin_gate();
   endtask

   task automatic model_rise();
`ifdef PULSE_RATE_METER_SATURATE_EN
      if (m_c32 == 32'hFFFF_FFFF) m_s32 = 1'b1; else m_c32 = m_c32 + 32'd1;
      if (m_c4 == 4'hF) m_s4 = 1'b1; else m_c4 = m_c4 + 4'd1;
`else
      if (m_c32 == 32'hFFFF_FFFF) m_s32 = 1'b1;
      m_c32 = m_c32 + 32'd1;
      if (m_c4 == 4'hF) m_s4 = 1'b1;
      m_c4 = m_c4 + 4'd1;
`endif
   endtask

   task automatic drive(input int n, input int hi, input int lo, input int phase, input bit ack_last);
      for (int i = 0; i < n; i++) begin
         pin = (((m_cyc + phase) % (hi + lo)) < hi);
         if (pin && !m_prev) model_rise();
         m_prev    = pin;
         count_ack = ack_last && (i == n - 1);
         tick();
         m_cyc++;
      end
      count_ack = 1'b0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.c32 = m_c32;
      e.s32 = m_s32;
      e.c4  = m_c4;
      e.s4  = m_s4;
      sb_q.push_back(e);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      check({tag, "_valid"}, count_valid, 1);
      check({tag, "_sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_count"}, count_out, e.c32);
         check({tag, "_ovf"}, overflow, e.s32);
         check({tag, "_count_w4"}, count_out4, e.c4);
         check({tag, "_ovf_w4"}, overflow4, e.s4);
         last_cnt = e.c32;
      end
   endtask

   task automatic stop();
      enable = 1'b0;
      tick();
      tick();
   endtask

   task automatic ack();
      count_ack = 1'b1;
      tick();
      count_ack = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      last_cnt  = '0;
      reset     = 1'b1;
      pin       = 1'b0;
      enable    = 1'b0;
      gate_len  = '0;
      count_ack = 1'b0;
      m_prev    = 1'b0;
      begin_gate();
      tick();
      tick();
      check("rst_count", count_out, 0);
      check("rst_valid", count_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_missed", missed, 0);
      reset = 1'b0;
      tick();

      // 100-cycle gate, 3 high / 7 low, gate_len changed mid-gate
      start_gate(100, 1'b0);
      drive(50, 3, 7, 0, 1'b0);
      gate_len = 7;
      drive(49, 3, 7, 0, 1'b0);
      check("g100_valid_early", count_valid, 0);
      drive(1, 3, 7, 0, 1'b0);
      push_exp();
      check_result("g100");
      stop();
      ack();
      check("g100_ack_valid", count_valid, 0);

      // two back-to-back gates without ack: second result dropped
      start_gate(20, 1'b0);
      drive(20, 5, 5, 0, 1'b0);
      push_exp();
      check_result("b2b_first");
      begin_gate();
      drive(19, 5, 5, 0, 1'b0);
      check("b2b_missed_early", missed, 0);
      drive(1, 5, 5, 0, 1'b0);
      check("b2b_missed", missed, 1);
      check("b2b_valid_held", count_valid, 1);
      check("b2b_count_held", count_out, last_cnt);
      stop();
      ack();
      check("b2b_ack_valid", count_valid, 0);
      check("b2b_ack_missed", missed, 0);

      // ack on the gate-end cycle loads the new result
      start_gate(10, 1'b0);
      drive(10, 2, 3, 0, 1'b0);
      push_exp();
      check_result("ackend_a");
      begin_gate();
      drive(10, 2, 3, 0, 1'b0);
      check("ackend_missed_set", missed, 1);
      begin_gate();
      drive(10, 1, 1, 0, 1'b1);
      push_exp();
      check_result("ackend_c");
      check("ackend_missed_clr", missed, 0);
      stop();
      ack();

      // 32 edges in 64 cycles: wraps or saturates in the 4-bit instance
      start_gate(64, 1'b0);
      drive(64, 1, 1, 0, 1'b0);
      push_exp();
      check_result("ovf64");
      stop();
      ack();

      // abort mid-gate publishes nothing
      start_gate(50, 1'b0);
      drive(10, 3, 2, 0, 1'b0);
      stop();
      drive(50, 1, 1, 0, 1'b0);
      check("abort_valid", count_valid, 0);
      check("abort_missed", missed, 0);

      // reset during a running gate clears outputs immediately
      start_gate(20, 1'b0);
      drive(20, 3, 2, 0, 1'b0);
      push_exp();
      check_result("prereset");
      begin_gate();
      drive(7, 3, 2, 0, 1'b0);
      reset = 1'b1;
      #1;
      check("mid_rst_count", count_out, 0);
      check("mid_rst_valid", count_valid, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_missed", missed, 0);
      enable = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("post_rst_valid", count_valid, 0);

      // input held high across gate start, one fall and one rise
      start_gate(10, 1'b1);
      drive(10, 5, 2, 2, 1'b0);
      push_exp();
      check_result("held_high");
      stop();
      ack();

      // one-cycle gates yielding 1 then 0
      start_gate(1, 1'b0);
      drive(1, 1, 1, 0, 1'b0);
      push_exp();
      check_result("len1_one");
      begin_gate();
      drive(1, 1, 1, 1, 1'b1);
      push_exp();
      check_result("len1_zero");
      stop();
      ack();

      // gate_len 0 keeps the meter disabled
      enable   = 1'b1;
      gate_len = 0;
      pin      = 1'b0;
      for (int i = 0; i < 20; i++) begin
         pin = ~pin;
         tick();
      end
      check("len0_valid", count_valid, 0);
      enable = 1'b0;
      tick();

      check("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pulse_rate_meter
